shift_arbiter: RTL and testbench

//  Shares one shifter instance (16-bit, ops: 00 sll, 01 srl, 10 rol, 11 ror) between two requesters.

---
 rtl/shift_arbiter.sv | 88 ++++++++
 tb/tb_shift_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one 16-bit shifter (sll/srl/rol/ror) between two requesters.
// Result is registered together with the owning requester's tag, with valid/ready on every side.
module shift_arbiter #(
    parameter int OPERAND_WIDTH  = 16,
    parameter int SHAMT_WIDTH    = 4,
    parameter int NUM_OPERATIONS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req0_valid,
    output logic                      req0_ready,
    input  logic [OPERAND_WIDTH-1:0]  req0_in,
    input  logic [SHAMT_WIDTH-1:0]    req0_shamt,
    input  logic [NUM_OPERATIONS-1:0] req0_oper,
    input  logic                      req1_valid,
    output logic                      req1_ready,
    input  logic [OPERAND_WIDTH-1:0]  req1_in,
    input  logic [SHAMT_WIDTH-1:0]    req1_shamt,
    input  logic [NUM_OPERATIONS-1:0] req1_oper,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [OPERAND_WIDTH-1:0]  resp_out,
    output logic                      resp_id
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t                      state;
    logic                        rr_ptr;
    logic                        accept_ok;
    logic                        grant0;
    logic                        grant1;
    logic [OPERAND_WIDTH-1:0]    sel_in;
    logic [SHAMT_WIDTH-1:0]      sel_shamt;
    logic [NUM_OPERATIONS-1:0]   sel_oper;
    logic [OPERAND_WIDTH-1:0]    shift_result;
    logic [2*OPERAND_WIDTH-1:0]  dbl;
    logic [2*OPERAND_WIDTH-1:0]  rot_left;
    logic [2*OPERAND_WIDTH-1:0]  rot_right;

    // Requester 1 wins when it is alone or when both are valid and rr_ptr favours it.
    always_comb begin
        accept_ok  = (state == IDLE) || ((state == HOLD) && resp_ready);
        grant1     = req1_valid && (!req0_valid || rr_ptr);
        grant0     = req0_valid && !grant1;
        req0_ready = accept_ok && grant0;
        req1_ready = accept_ok && grant1;
    end

    always_comb begin
        sel_in    = grant1 ? req1_in    : req0_in;
        sel_shamt = grant1 ? req1_shamt : req0_shamt;
        sel_oper  = grant1 ? req1_oper  : req0_oper;
    end

    // Rotates shift a doubled copy of the operand so wrapped bits fall into the kept half.
    always_comb begin
        dbl       = {sel_in, sel_in};
        rot_left  = dbl << sel_shamt;
        rot_right = dbl >> sel_shamt;
        case (sel_oper)
            2'b00:   shift_result = sel_in << sel_shamt;
            2'b01:   shift_result = sel_in >> sel_shamt;
            2'b10:   shift_result = rot_left[2*OPERAND_WIDTH-1:OPERAND_WIDTH];
            default: shift_result = rot_right[OPERAND_WIDTH-1:0];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_out   <= '0;
            resp_id    <= 1'b0;
            rr_ptr     <= 1'b0;
        end else if (accept_ok && (grant0 || grant1)) begin
            state      <= HOLD;
            resp_valid <= 1'b1;
            resp_out   <= shift_result;
            resp_id    <= grant1;
            rr_ptr     <= ~grant1;
        end else if ((state == HOLD) && resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: handshake model, result scoreboard, vector table and directed sequences.
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_in, req1_in;
    logic [3:0]  req0_shamt, req1_shamt;
    logic [1:0]  req0_oper, req1_oper;
    logic        resp_valid, resp_ready;
    logic [15:0] resp_out;
    logic        resp_id;

    shift_arbiter #(.OPERAND_WIDTH(16), .SHAMT_WIDTH(4), .NUM_OPERATIONS(2)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in(req0_in),
        .req0_shamt(req0_shamt), .req0_oper(req0_oper),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in(req1_in),
        .req1_shamt(req1_shamt), .req1_oper(req1_oper),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_out(resp_out), .resp_id(resp_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic        id;
    } resp_t;

    typedef struct {
        logic [15:0] in;
        logic [3:0]  shamt;
        logic [1:0]  oper;
        logic [15:0] exp;
    } vec_t;

    resp_t sb[$];
    int    total = 0;
    int    bad   = 0;
    logic  m_hold = 1'b0;
    logic  m_rr   = 1'b0;

    function automatic logic [15:0] golden(input logic [15:0] x, input logic [3:0] s, input logic [1:0] op);
        logic [15:0] r = x;
        for (int i = 0; i < int'(s); i++) begin
            case (op)
                2'b00: r = {r[14:0], 1'b0};
                2'b01: r = {1'b0, r[15:1]};
                2'b10: r = {r[14:0], r[15]};
                default: r = {r[0], r[15:1]};
            endcase
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called just after a falling edge with inputs already driven; ends after the next falling edge.
    task automatic step(input logic [15:0] e0, input logic [15:0] e1);
        logic g0, g1, acc;
        resp_t r;
        #2;
        g1  = req1_valid && (!req0_valid || m_rr);
        g0  = req0_valid && !g1;
        acc = !m_hold || resp_ready;
        chk("req0_ready", {31'b0, req0_ready}, {31'b0, acc && g0});
        chk("req1_ready", {31'b0, req1_ready}, {31'b0, acc && g1});
        chk("resp_valid", {31'b0, resp_valid}, {31'b0, m_hold});
        if (resp_valid) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL sb_underflow: got resp_valid=1 expected no pending result");
            end else begin
                r = sb[0];
                chk("resp_out", {16'b0, resp_out}, {16'b0, r.d});
                chk("resp_id", {31'b0, resp_id}, {31'b0, r.id});
                if (resp_ready) void'(sb.pop_front());
            end
        end
        if (req0_ready) sb.push_back('{d: e0, id: 1'b0});
        if (req1_ready) sb.push_back('{d: e1, id: 1'b1});
        if (acc && (g0 || g1)) begin
            m_hold = 1'b1;
            m_rr   = !g1;
        end else if (resp_ready) begin
            m_hold = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step_g();
        step(golden(req0_in, req0_shamt, req0_oper), golden(req1_in, req1_shamt, req1_oper));
    endtask

    task automatic set0(input logic v, input logic [15:0] d, input logic [3:0] s, input logic [1:0] op);
        req0_valid = v; req0_in = d; req0_shamt = s; req0_oper = op;
    endtask

    task automatic set1(input logic v, input logic [15:0] d, input logic [3:0] s, input logic [1:0] op);
        req1_valid = v; req1_in = d; req1_shamt = s; req1_oper = op;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        m_hold = 1'b0;
        m_rr   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t vt[12];

    initial begin
        vt[0]  = '{16'h8001, 4'd1,  2'b10, 16'h0003};
        vt[1]  = '{16'hF000, 4'd4,  2'b01, 16'h0F00};
        vt[2]  = '{16'h1234, 4'd8,  2'b11, 16'h3412};
        vt[3]  = '{16'hABCD, 4'd8,  2'b11, 16'hCDAB};
        vt[4]  = '{16'h0001, 4'd15, 2'b00, 16'h8000};
        vt[5]  = '{16'hFFFF, 4'd15, 2'b01, 16'h0001};
        vt[6]  = '{16'h1234, 4'd0,  2'b00, 16'h1234};
        vt[7]  = '{16'h8000, 4'd1,  2'b10, 16'h0001};
        vt[8]  = '{16'h0001, 4'd1,  2'b11, 16'h8000};
        vt[9]  = '{16'hABCD, 4'd4,  2'b00, 16'hBCD0};
        vt[10] = '{16'hABCD, 4'd4,  2'b01, 16'h0ABC};
        vt[11] = '{16'hABCD, 4'd4,  2'b10, 16'hBCDA};

        set0(1'b0, 16'h0, 4'd0, 2'b00);
        set1(1'b0, 16'h0, 4'd0, 2'b00);
        resp_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        do_reset();
        step_g();

        // Async reset while holding a result, between clock edges.
        set0(1'b1, 16'h00F0, 4'd4, 2'b00);
        step_g();
        set0(1'b0, 16'h0, 4'd0, 2'b00);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_out", {16'b0, resp_out}, 32'd0);
        #1;
        do_reset();

        // Both valid right after reset: requester 0 first, then requester 1.
        resp_ready = 1'b1;
        set0(1'b1, 16'hF000, 4'd4, 2'b01);
        set1(1'b1, 16'h1234, 4'd8, 2'b11);
        step(16'h0F00, 16'h3412);
        set0(1'b0, 16'h0, 4'd0, 2'b00);
        step(16'h0, 16'h3412);
        chk("t3_first_id", {31'b0, resp_id}, 32'd1);
        set1(1'b0, 16'h0, 4'd0, 2'b00);
        step_g();

        // Single requester 0 rotate.
        set0(1'b1, 16'h8001, 4'd1, 2'b10);
        step(16'h0003, 16'h0);
        set0(1'b0, 16'h0, 4'd0, 2'b00);
        chk("t2_valid", {31'b0, resp_valid}, 32'd1);
        chk("t2_out", {16'b0, resp_out}, 32'h0003);
        chk("t2_id", {31'b0, resp_id}, 32'd0);
        resp_ready = 1'b0;

        // Backpressure: three stalled cycles, then release with requester 1 waiting.
        set0(1'b1, 16'h0F0F, 4'd3, 2'b10);
        set1(1'b1, 16'h5555, 4'd1, 2'b00);
        for (int i = 0; i < 3; i++) step_g();
        resp_ready = 1'b1;
        set0(1'b0, 16'h0, 4'd0, 2'b00);
        #1;
        chk("t4_req1_ready", {31'b0, req1_ready}, 32'd1);
        #1;
        step_g();  // step's own #2 is absorbed: readys settle well before the edge
        set1(1'b0, 16'h0, 4'd0, 2'b00);
        step_g();
        step_g();

        // Fairness after reset.
        do_reset();
        resp_ready = 1'b1;
        set0(1'b1, 16'h1111, 4'd1, 2'b00);
        set1(1'b1, 16'h2222, 4'd2, 2'b01);
        for (int i = 0; i < 8; i++) begin
            step_g();
            chk("t5_id_seq", {31'b0, resp_id}, i % 2);
        end
        set0(1'b0, 16'h0, 4'd0, 2'b00);
        set1(1'b0, 16'h0, 4'd0, 2'b00);
        step_g();

        // Vector table alternating ports.
        for (int i = 0; i < 12; i++) begin
            if (i % 2 == 0) begin
                set0(1'b1, vt[i].in, vt[i].shamt, vt[i].oper);
                set1(1'b0, 16'h0, 4'd0, 2'b00);
            end else begin
                set0(1'b0, 16'h0, 4'd0, 2'b00);
                set1(1'b1, vt[i].in, vt[i].shamt, vt[i].oper);
            end
            step(vt[i].exp, vt[i].exp);
        end

        // Sweep every op and shift amount with random operands through both ports.
        for (int op = 0; op < 4; op++) begin
            for (int s = 0; s < 16; s++) begin
                if (((op * 16 + s) % 2) == 0) begin
                    set0(1'b1, 16'($urandom), 4'(s), 2'(op));
                    set1(1'b0, 16'h0, 4'd0, 2'b00);
                end else begin
                    set0(1'b0, 16'h0, 4'd0, 2'b00);
                    set1(1'b1, 16'($urandom), 4'(s), 2'(op));
                end
                step_g();
            end
        end

        set0(1'b0, 16'h0, 4'd0, 2'b00);
        set1(1'b0, 16'h0, 4'd0, 2'b00);
        for (int i = 0; i < 10 && (sb.size() != 0 || resp_valid); i++) step_g();
        chk("drain_empty", sb.size(), 32'd0);
        chk("drain_idle", {31'b0, resp_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
